// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;
    typedef enum logic {RUN, MD_WAIT} md_state_e;
    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;
    localparam logic [31:0] EXC_VECTOR      = 32'h0000_4180;
endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// pipe_stall_ctrl_if: hazard/MDU/exception inputs and pipeline enable/flush outputs.
interface pipe_stall_ctrl_if;
    logic        hazard_D;
    logic        md_use_D;
    logic        md_start_E;
    logic        md_div_E;
    logic        exc_req_M;
    logic        eret_M;
    logic        pc_en;
    logic        fd_en;
    logic        fd_flush;
    logic        de_flush;
    logic        em_flush;
    logic        mw_flush;
    logic        pc_sel_exc;
    logic        pc_sel_epc;
    logic        md_start_ok;
    logic        md_busy;
    logic [31:0] stall_cycles;
    modport master (
        output hazard_D, md_use_D, md_start_E, md_div_E, exc_req_M, eret_M,
        input  pc_en, fd_en, fd_flush, de_flush, em_flush, mw_flush,
               pc_sel_exc, pc_sel_epc, md_start_ok, md_busy, stall_cycles
    );
    modport slave (
        input  hazard_D, md_use_D, md_start_E, md_div_E, exc_req_M, eret_M,
        output pc_en, fd_en, fd_flush, de_flush, em_flush, mw_flush,
               pc_sel_exc, pc_sel_epc, md_start_ok, md_busy, stall_cycles
    );
endinterface

// File: rtl/md_busy_timer.sv
// md_busy_timer: RUN/MD_WAIT sequencer with a down-counter tracking MDU latency.
module md_busy_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    input  logic is_div_i,
    output logic busy_o
);
    localparam logic [4:0] MC = 5'(MULT_CYCLES);
    localparam logic [4:0] DC = 5'(DIV_CYCLES);
    md_state_e  state_q, state_d;
    logic [4:0] md_cnt_q, md_cnt_d;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RUN;
            md_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end
    // A start always wins, so a start on the expiring cycle reloads with no gap.
    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        if (start_i) begin
            state_d  = MD_WAIT;
            md_cnt_d = is_div_i ? DC : MC;
        end else if (state_q == MD_WAIT) begin
            md_cnt_d = md_cnt_q - 5'd1;
            state_d  = (md_cnt_q == 5'd1) ? RUN : MD_WAIT;
        end
    end
    assign busy_o = (state_q == MD_WAIT);
endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: PC/F2D enables and register flushes from hazards, MDU busy and exceptions.
// Optional stall-cycle counter enabled by PIPE_STALL_CNT_EN.
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input logic              clk,
    input logic              reset,
    pipe_stall_ctrl_if.slave bus
);
    logic md_start_ok, md_busy, stall, redirect, pc_en;
    assign md_start_ok = bus.md_start_E & ~bus.exc_req_M & ~bus.eret_M;
    md_busy_timer #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .start_i (md_start_ok),
        .is_div_i(bus.md_div_E),
        .busy_o  (md_busy)
    );
    assign stall    = bus.hazard_D | (bus.md_use_D & (md_busy | bus.md_start_E));
    // Exception and eret both override any stall; the M instruction itself still retires.
    assign redirect = bus.exc_req_M | bus.eret_M;
    assign pc_en    = redirect | ~stall;
    assign bus.pc_en       = pc_en;
    assign bus.fd_en       = pc_en;
    assign bus.fd_flush    = redirect;
    assign bus.de_flush    = redirect | stall;
    assign bus.em_flush    = redirect;
    assign bus.mw_flush    = 1'b0;
    assign bus.pc_sel_exc  = bus.exc_req_M;
    assign bus.pc_sel_epc  = ~bus.exc_req_M & bus.eret_M;
    assign bus.md_start_ok = md_start_ok;
    assign bus.md_busy     = md_busy;
`ifdef PIPE_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    assign stall_cnt_d = pc_en ? stall_cnt_q : stall_cnt_q + 32'd1;
    always_ff @(posedge clk) begin
        if (reset) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
    end
    assign bus.stall_cycles = stall_cnt_q;
`else
    assign bus.stall_cycles = '0;
`endif
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: scoreboard bench; expected responses come from a cycle-indexed busy-window model.
module tb_pipe_stall_ctrl;
    localparam int MC = 5;
    localparam int DC = 10;
    typedef struct packed {
        logic [9:0]  ctl;
        logic [31:0] sc;
    } exp_t;
    logic clk = 1'b0;
    logic reset;
    pipe_stall_ctrl_if bus ();
    pipe_stall_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );
    always #5 clk = ~clk;
    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          k = 0;
    int          last_s = -100;
    int          last_n = 0;
    logic [31:0] sc_m = '0;
    // Model: the MDU is busy in cycle k iff k lies in (last_start, last_start + latency].
    task automatic step(input logic h, u, s, dv, e, er, rs);
        logic busy, ok, stl, pc;
        exp_t x;
        bus.hazard_D = h; bus.md_use_D = u; bus.md_start_E = s;
        bus.md_div_E = dv; bus.exc_req_M = e; bus.eret_M = er; reset = rs;
        busy = (k > last_s) && (k <= last_s + last_n);
        ok   = s && !e && !er;
        stl  = h || (u && (busy || s));
        if (e)       x.ctl = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, ok, busy};
        else if (er) x.ctl = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, ok, busy};
        else if (stl) x.ctl = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ok, busy};
        else         x.ctl = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ok, busy};
        pc = x.ctl[9];
`ifdef PIPE_STALL_CNT_EN
        x.sc = sc_m;
`else
        x.sc = '0;
`endif
        q.push_back(x);
        @(posedge clk);
        if (rs) begin
            last_s = -100;
            sc_m   = '0;
        end else begin
            if (ok) begin
                last_s = k;
                last_n = dv ? DC : MC;
            end
            if (!pc) sc_m = sc_m + 32'd1;
        end
        k++;
        #1;
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t x;
            logic [9:0] got;
            x = q.pop_front();
            got = {bus.pc_en, bus.fd_en, bus.fd_flush, bus.de_flush, bus.em_flush, bus.mw_flush,
                   bus.pc_sel_exc, bus.pc_sel_epc, bus.md_start_ok, bus.md_busy};
            checks += 2;
            if (got !== x.ctl) begin
                errors++;
                $display("FAIL ctl cycle %0d: got pc,fd,fdf,def,emf,mwf,exc,epc,ok,busy=%b expected %b",
                         k, got, x.ctl);
            end
            if (bus.stall_cycles !== x.sc) begin
                errors++;
                $display("FAIL stall_cycles cycle %0d: got %0d expected %0d", k, bus.stall_cycles, x.sc);
            end
        end
    end
    initial begin
        {bus.hazard_D, bus.md_use_D, bus.md_start_E, bus.md_div_E, bus.exc_req_M, bus.eret_M} = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        step(0, 0, 0, 0, 0, 0, 1);
        idle(2);
        step(1, 0, 0, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0, 0);
        idle(1);
        step(0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0, 0, 0);
        idle(1);
        step(0, 1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 11; i++) step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 1, 0, 0);
        step(0, 1, 1, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1, 0, 0);
        idle(1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0);
        idle(1);
        step(0, 0, 0, 0, 0, 0, 1);
        idle(1);
        step(0, 0, 1, 1, 0, 0, 0);
        idle(3);
        step(0, 1, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        idle(4);
        step(0, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 1, 0, 0);
        idle(2);
        for (int i = 0; i < 800; i++)
            step($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 15,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 5,
                 $urandom_range(0, 99) < 2);
        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected responses never compared, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
